// File: rtl/sc_debounce_jug2_if.sv
// Player-2 button bus: raw active-low buttons in, debounced active-low levels out.
interface sc_debounce_jug2_if;
  logic SC_DEBOUNCE_JUG2_startRaw_InLow;
  logic SC_DEBOUNCE_JUG2_leftRaw_InLow;
  logic SC_DEBOUNCE_JUG2_rightRaw_InLow;
  logic SC_DEBOUNCE_JUG2_start_OutLow;
  logic SC_DEBOUNCE_JUG2_left_OutLow;
  logic SC_DEBOUNCE_JUG2_right_OutLow;
  logic SC_DEBOUNCE_JUG2_anyPressed_Out;

  modport master (
    output SC_DEBOUNCE_JUG2_startRaw_InLow,
    output SC_DEBOUNCE_JUG2_leftRaw_InLow,
    output SC_DEBOUNCE_JUG2_rightRaw_InLow,
    input  SC_DEBOUNCE_JUG2_start_OutLow,
    input  SC_DEBOUNCE_JUG2_left_OutLow,
    input  SC_DEBOUNCE_JUG2_right_OutLow,
    input  SC_DEBOUNCE_JUG2_anyPressed_Out
  );

  modport slave (
    input  SC_DEBOUNCE_JUG2_startRaw_InLow,
    input  SC_DEBOUNCE_JUG2_leftRaw_InLow,
    input  SC_DEBOUNCE_JUG2_rightRaw_InLow,
    output SC_DEBOUNCE_JUG2_start_OutLow,
    output SC_DEBOUNCE_JUG2_left_OutLow,
    output SC_DEBOUNCE_JUG2_right_OutLow,
    output SC_DEBOUNCE_JUG2_anyPressed_Out
  );
endinterface

// File: rtl/sc_debounce_jug2.sv
// Player-2 button conditioning: per-channel 2-flop sync + stability-window debounce FSM.
module sc_debounce_jug2 #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic               SC_STATEMACHINE_JUG2_CLOCK_50,
  input  logic               SC_STATEMACHINE_JUG2_RESET_InHigh,
  sc_debounce_jug2_if.slave  bus
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] out_q;
  logic [NUM_LANES-1:0] out_nx;
  logic                 any_q;

  // Lane order: 0 = start, 1 = left, 2 = right.
  assign raw = {bus.SC_DEBOUNCE_JUG2_rightRaw_InLow,
                bus.SC_DEBOUNCE_JUG2_leftRaw_InLow,
                bus.SC_DEBOUNCE_JUG2_startRaw_InLow};

  sc_debounce_jug2_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_lane [NUM_LANES-1:0] (
    .clk    (SC_STATEMACHINE_JUG2_CLOCK_50),
    .rst    (SC_STATEMACHINE_JUG2_RESET_InHigh),
    .raw    (raw),
    .out_nx (out_nx),
    .out_q  (out_q)
  );

  // Built from the lanes' next outputs so it lands on the same edge as them.
  always_ff @(posedge SC_STATEMACHINE_JUG2_CLOCK_50 or posedge SC_STATEMACHINE_JUG2_RESET_InHigh) begin
    if (SC_STATEMACHINE_JUG2_RESET_InHigh) any_q <= 1'b0;
    else                                   any_q <= ~&out_nx;
  end

  assign bus.SC_DEBOUNCE_JUG2_start_OutLow   = out_q[0];
  assign bus.SC_DEBOUNCE_JUG2_left_OutLow    = out_q[1];
  assign bus.SC_DEBOUNCE_JUG2_right_OutLow   = out_q[2];
  assign bus.SC_DEBOUNCE_JUG2_anyPressed_Out = any_q;
endmodule

// One channel: synchroniser, stability counter and 4-state debounce FSM.
module sc_debounce_jug2_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out_nx,
  output logic out_q
);
  typedef enum logic [1:0] {
    STABLE_HIGH = 2'd0,
    WAIT_LOW    = 2'd1,
    STABLE_LOW  = 2'd2,
    WAIT_HIGH   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_q, state_nx;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nx;
  logic                 s1, s2;

  // Raw button is asynchronous; only s2 is ever looked at by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_HIGH;
      cnt_q   <= '0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      out_q   <= out_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    out_nx   = out_q;
    case (state_q)
      STABLE_HIGH: begin
        cnt_nx = '0;
        if (!s2) state_nx = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nx = STABLE_HIGH;
          cnt_nx   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_nx = STABLE_LOW;
          cnt_nx   = '0;
          out_nx   = 1'b0;
        end else begin
          cnt_nx = cnt_q + CNT_ONE;
        end
      end
      STABLE_LOW: begin
        cnt_nx = '0;
        if (s2) state_nx = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nx = STABLE_LOW;
          cnt_nx   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_nx = STABLE_HIGH;
          cnt_nx   = '0;
          out_nx   = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_nx = STABLE_HIGH;
        cnt_nx   = '0;
        out_nx   = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_sc_debounce_jug2.sv
// Directed bench for sc_debounce_jug2 with a run-length reference model checked every cycle.
module tb_sc_debounce_jug2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] raw = 3'b111;   // {right, left, start}, active low
  int         checks = 0;
  int         failures = 0;
  logic       cmp_en = 1'b0;

  sc_debounce_jug2_if bus ();

  assign bus.SC_DEBOUNCE_JUG2_startRaw_InLow = raw[0];
  assign bus.SC_DEBOUNCE_JUG2_leftRaw_InLow  = raw[1];
  assign bus.SC_DEBOUNCE_JUG2_rightRaw_InLow = raw[2];

  sc_debounce_jug2 #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)) dut (
    .SC_STATEMACHINE_JUG2_CLOCK_50     (clk),
    .SC_STATEMACHINE_JUG2_RESET_InHigh (rst),
    .bus                               (bus)
  );

  initial forever #5 clk = ~clk;

  // {anyPressed, right, left, start}
  wire [3:0] dut_v = {bus.SC_DEBOUNCE_JUG2_anyPressed_Out, bus.SC_DEBOUNCE_JUG2_right_OutLow,
                      bus.SC_DEBOUNCE_JUG2_left_OutLow, bus.SC_DEBOUNCE_JUG2_start_OutLow};

  // Model: the debouncer sees each raw sample two edges late; an output flips to a level
  // once D+1 consecutive seen samples disagree with it. Reset restarts everything at 1.
  logic [2:0] m_h1, m_h2, m_out;
  int         m_run [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h1  <= 3'b111;
      m_h2  <= 3'b111;
      m_out <= 3'b111;
      for (int c = 0; c < 3; c++) m_run[c] <= 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (m_h2[c] == m_out[c]) m_run[c] <= 0;
        else if (m_run[c] + 1 >= D + 1) begin
          m_run[c] <= 0;
          m_out[c] <= m_h2[c];
        end else m_run[c] <= m_run[c] + 1;
      end
      m_h2 <= m_h1;
      m_h1 <= raw;
    end
  end

  wire [3:0] model_v = {~&m_out, m_out};

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (cmp_en) chk("model", dut_v, model_v);

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset with all buttons pressed
    #1 rst = 1'b1;
    raw = 3'b000;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_vals", dut_v, 4'b0111);
    edges(2);
    chk("reset_vals_held", dut_v, 4'b0111);
    raw = 3'b101;             // left held through release
    rst = 1'b0;
    edges(6);
    chk("rel_left_k5", dut_v, 4'b0111);
    edges(1);
    chk("rel_left_k6", dut_v, 4'b1101);
    raw = 3'b111;
    edges(8);
    chk("left_released", dut_v, 4'b0111);

    // 2. clean start press, 20 cycles, release
    raw = 3'b110;
    edges(6);
    chk("start_press_k5", dut_v, 4'b0111);
    edges(1);
    chk("start_press_k6", dut_v, 4'b1110);
    edges(13);
    raw = 3'b111;
    edges(6);
    chk("start_rel_k5", dut_v, 4'b1110);
    edges(1);
    chk("start_rel_k6", dut_v, 4'b0111);

    // 3. right bounce then hold, then a 3-cycle pulse
    for (int i = 0; i < 2; i++) begin
      raw = 3'b011; edges(2);
      raw = 3'b111; edges(2);
    end
    chk("bounce_no_out", dut_v, 4'b0111);
    raw = 3'b011;
    edges(6);
    chk("bounce_hold_k5", dut_v, 4'b0111);
    edges(1);
    chk("bounce_hold_k6", dut_v, 4'b1011);
    raw = 3'b111;
    edges(8);
    raw = 3'b011; edges(3);
    raw = 3'b111; edges(8);
    chk("short_pulse", dut_v, 4'b0111);

    // 4. left+right together, right released after 2 cycles
    raw = 3'b001;
    edges(2);
    raw = 3'b101;
    edges(4);
    chk("indep_k5", dut_v, 4'b0111);
    edges(1);
    chk("indep_k6", dut_v, 4'b1101);
    edges(5);
    chk("indep_hold", dut_v, 4'b1101);
    raw = 3'b111;
    edges(8);
    chk("indep_rel", dut_v, 4'b0111);

    // 5. reset on cycle 3 of WAIT_LOW, start still held
    raw = 3'b110;
    edges(5);
    rst = 1'b1;
    #1;
    chk("midwin_rst", dut_v, 4'b0111);
    edges(3);
    chk("midwin_rst_hold", dut_v, 4'b0111);
    rst = 1'b0;
    edges(6);
    chk("midwin_rel_k5", dut_v, 4'b0111);
    edges(1);
    chk("midwin_rel_k6", dut_v, 4'b1110);
    raw = 3'b111;
    edges(8);

    // 6. long hold of left
    raw = 3'b101;
    edges(7);
    chk("long_start", dut_v, 4'b1101);
    edges(1000);
    chk("long_end", dut_v, 4'b1101);
    raw = 3'b111;
    edges(8);
    chk("final_idle", dut_v, 4'b0111);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
